// File: rtl/seq_multdiv_if.sv
// Execute-stage <-> multiply/divide unit handshake bundle.
// Ports: operands and start strobes from the execute stage; result, exception,
//        one-cycle ready strobe and busy level back from the unit.
interface seq_multdiv_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;

  // Execute stage side: drives operands/strobes, consumes results.
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, data_busy
  );

  // Multiply/divide unit side.
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, data_busy
  );
endinterface

// File: rtl/seq_multdiv.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) unit.
// Latency: fixed 33 edges from start edge to the end of the one-cycle ready strobe.
// Backpressure: none; a new start strobe aborts any in-flight operation.
// Ports: clock, reset (async active-high); bus (slave modport) carries operands,
//        ctrl_MULT/ctrl_DIV strobes, data_result, data_exception, data_resultRDY, data_busy.
module seq_multdiv (
  input  logic        clock,
  input  logic        reset,
  seq_multdiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        is_div;
  logic        sign_q;
  logic        divzero_q;
  logic [31:0] a_mag;      // |A|: multiplicand magnitude
  logic [31:0] b_mag;      // |B|: divisor magnitude
  logic [31:0] shreg;      // multiplier bits (shift right) or dividend bits (shift left)
  logic [63:0] acc;        // multiply: product accumulator; divide: {remainder, quotient}
  logic [31:0] result_q;
  logic        exc_q;
  logic        rdy_q;
  logic        busy_q;

  logic        start;
  logic [31:0] opa_mag;
  logic [31:0] opb_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic        div_ok;
  logic [31:0] rem_new;
  logic [63:0] div_next;
  logic [63:0] acc_next;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] fin_res;
  logic        fin_exc;

  // Both strobes on one edge resolve to multiply (is_div gated by ctrl_MULT).
  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  always_comb begin
    opa_mag = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
    opb_mag = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;

    // Multiply step: add |A| into the upper half when the multiplier LSB is set,
    // the carry lands in bit 63 after the right shift.
    mul_sum  = {1'b0, acc[63:32]} + (shreg[0] ? {1'b0, a_mag} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};

    // Divide step: bring the next dividend MSB into the remainder and trial-subtract.
    // The kept remainder is always < |B| <= 2^31, so 32 bits suffice to store it.
    rem_sh   = {acc[63:32], shreg[31]};
    div_diff = {1'b0, rem_sh} - {2'b00, b_mag};
    div_ok   = ~div_diff[33];
    rem_new  = div_ok ? div_diff[31:0] : rem_sh[31:0];
    div_next = {rem_new, acc[30:0], div_ok};

    acc_next = is_div ? div_next : mul_next;

    prod_s = sign_q ? (~acc_next + 64'd1) : acc_next;
    quot_s = sign_q ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];

    if (!is_div) begin
      fin_res = prod_s[31:0];
      // Product fits in 32 signed bits only if bits 63..31 are a pure sign extension.
      fin_exc = ~((&prod_s[63:31]) | ~(|prod_s[63:31]));
    end else if (divzero_q) begin
      fin_res = 32'd0;
      fin_exc = 1'b1;
    end else begin
      fin_res = quot_s;
      // Q reaches 2^31 only for |A| = 2^31, |B| = 1; positive sign means -2^31 / -1.
      fin_exc = ~sign_q & acc_next[31];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      is_div    <= 1'b0;
      sign_q    <= 1'b0;
      divzero_q <= 1'b0;
      a_mag     <= 32'd0;
      b_mag     <= 32'd0;
      shreg     <= 32'd0;
      acc       <= 64'd0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        // Restart from any state; an aborted operation never raises ready.
        state     <= RUN;
        cnt       <= 6'd0;
        is_div    <= ~bus.ctrl_MULT;
        sign_q    <= bus.data_operandA[31] ^ bus.data_operandB[31];
        divzero_q <= (bus.data_operandB == 32'd0);
        a_mag     <= opa_mag;
        b_mag     <= opb_mag;
        shreg     <= bus.ctrl_MULT ? opb_mag : opa_mag;
        acc       <= 64'd0;
        busy_q    <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            acc   <= acc_next;
            shreg <= is_div ? {shreg[30:0], 1'b0} : {1'b0, shreg[31:1]};
            cnt   <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state    <= DONE;
              rdy_q    <= 1'b1;
              result_q <= fin_res;
              exc_q    <= fin_exc;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.data_busy      = busy_q;

endmodule
